pw_stepper: RTL and testbench

- Parametrised successor to the single-step password incrementer in the brute-force candidate pipeline.
- Advances a candidate password by a programmable step (1..RADIX-1) in the printable-character enumeration order. Processes one character per clock.
- Uses a valid/ready handshake on both input and output, so parallel crack cores can stride through the keyspace with interleaved offsets.
- Adds early termination, maximum-length exhaustion and illegal-character detection.

---
 rtl/pw_stepper.sv | 173 +++++++++++++++++
 tb/tb_pw_stepper.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pw_stepper.sv
// rtl/pw_stepper.sv - advances a candidate password by a programmable step, one character per clock
//
// Treats the password as a big-endian base-RADIX number over [CHAR_MIN, CHAR_MAX]
// and adds in_step to it. A carry out of index 0 grows the password by one
// character (new leading CHAR_MIN) unless it is already MAX_LEN long, in which
// case the input is returned unchanged with out_exhausted set.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid / in_ready              request handshake (ready only while idle)
//   in_password, in_length, in_step  candidate (index 0 in the top byte), length, increment
//   out_valid / out_ready            result handshake (result held until accepted)
//   out_password, out_length         result; bytes at index >= out_length are zero
//   out_exhausted                    carry ran past MAX_LEN, input echoed back
//   out_error                        illegal length, step or character, input echoed back
module pw_stepper #(
    parameter int         MAX_LEN  = 20,
    parameter logic [7:0] CHAR_MIN = 8'h20,
    parameter logic [7:0] CHAR_MAX = 8'h7E,
    localparam int        LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*MAX_LEN-1:0]   in_password,
    input  logic [LEN_W-1:0]       in_length,
    input  logic [7:0]             in_step,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*MAX_LEN-1:0]   out_password,
    output logic [LEN_W-1:0]       out_length,
    output logic                   out_exhausted,
    output logic                   out_error
);

    localparam int RADIX = int'(CHAR_MAX) - int'(CHAR_MIN) + 1;
    localparam int PW_W  = 8 * MAX_LEN;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DIGIT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW_W-1:0]   r_pw;
    logic [PW_W-1:0]   r_in_pw;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_in_len;
    logic [LEN_W-1:0]  r_idx;
    logic [7:0]        r_step;
    logic [7:0]        r_carry;
    logic              r_exh;
    logic              r_err;

    logic [PW_W-1:0]   w_in_masked;
    logic [PW_W-1:0]   w_pw_upd;
    logic [7:0]        w_cur_byte;
    logic [7:0]        w_new_byte;
    logic [8:0]        w_sum;
    logic [8:0]        w_sum_wrapped;
    logic              w_wrap;
    logic              w_bad_char;
    logic              w_err_chk;

    assign in_ready      = (r_state == S_IDLE);
    assign out_valid     = (r_state == S_DONE);
    assign out_password  = r_pw;
    assign out_length    = r_len;
    assign out_exhausted = r_exh;
    assign out_error     = r_err;

    // Datapath helpers: input masking, legality scan and the per-digit add.
    always_comb begin
        w_in_masked = '0;
        w_bad_char  = 1'b0;
        w_cur_byte  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(in_length))
                w_in_masked[PW_W-1-8*i -: 8] = in_password[PW_W-1-8*i -: 8];
            if (i < int'(r_in_len) &&
                (r_pw[PW_W-1-8*i -: 8] < CHAR_MIN || r_pw[PW_W-1-8*i -: 8] > CHAR_MAX))
                w_bad_char = 1'b1;
            if (i == int'(r_idx))
                w_cur_byte = r_pw[PW_W-1-8*i -: 8];
        end
        w_err_chk = w_bad_char || (int'(r_in_len) > MAX_LEN) || (int'(r_step) >= RADIX);

        // Operands are bounded by RADIX-1 each, so 9 bits never overflow.
        w_sum         = {1'b0, w_cur_byte - CHAR_MIN} + {1'b0, r_carry};
        w_wrap        = (w_sum >= 9'(RADIX));
        w_sum_wrapped = w_wrap ? (w_sum - 9'(RADIX)) : w_sum;
        w_new_byte    = w_sum_wrapped[7:0] + CHAR_MIN;

        w_pw_upd = r_pw;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i == int'(r_idx))
                w_pw_upd[PW_W-1-8*i -: 8] = w_new_byte;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_CHECK;
            S_CHECK: if (w_err_chk || r_step == 8'd0 || r_len == '0) w_state_nxt = S_DONE;
                     else w_state_nxt = S_DIGIT;
            S_DIGIT: if (!w_wrap || r_idx == '0) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pw     <= '0;
            r_in_pw  <= '0;
            r_len    <= '0;
            r_in_len <= '0;
            r_idx    <= '0;
            r_step   <= '0;
            r_carry  <= '0;
            r_exh    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_pw     <= w_in_masked;
                        r_in_pw  <= w_in_masked;
                        r_len    <= in_length;
                        r_in_len <= in_length;
                        r_step   <= in_step;
                        r_exh    <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_err_chk) begin
                        r_err <= 1'b1;
                    end else if (r_step == 8'd0) begin
                        // passthrough: latched values are already the result
                    end else if (r_len == '0) begin
                        r_pw[PW_W-1 -: 8] <= CHAR_MIN + r_step - 8'd1;
                        r_len             <= LEN_W'(1);
                    end else begin
                        r_idx   <= r_len - 1'b1;
                        r_carry <= r_step;
                    end
                end
                S_DIGIT: begin
                    if (!w_wrap) begin
                        r_pw <= w_pw_upd;
                    end else if (r_idx != '0) begin
                        r_pw    <= w_pw_upd;
                        r_carry <= 8'd1;
                        r_idx   <= r_idx - 1'b1;
                    end else if (int'(r_len) < MAX_LEN) begin
                        // Carry out of the leading digit: grow by one character.
                        r_pw  <= {CHAR_MIN, w_pw_upd[PW_W-1:8]};
                        r_len <= r_len + 1'b1;
                    end else begin
                        r_pw  <= r_in_pw;
                        r_len <= r_in_len;
                        r_exh <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_stepper.sv
// tb/tb_pw_stepper.sv - directed self-checking bench for pw_stepper
module tb_pw_stepper;

    localparam int ML = 20;
    localparam int LW = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [8*ML-1:0] in_password = '0;
    logic [LW-1:0]   in_length = '0;
    logic [7:0]      in_step = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [8*ML-1:0] out_password;
    logic [LW-1:0]   out_length;
    logic            out_exhausted;
    logic            out_error;

    int n_pass = 0;
    int n_total = 0;
    int lat;

    always #5 clk = ~clk;

    pw_stepper dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_password(in_password), .in_length(in_length), .in_step(in_step),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_password(out_password), .out_length(out_length),
        .out_exhausted(out_exhausted), .out_error(out_error)
    );

    function automatic logic [8*ML-1:0] pw_of(input string s);
        logic [8*ML-1:0] p = '0;
        for (int i = 0; i < s.len(); i++) p[8*ML-1-8*i -: 8] = s[i];
        return p;
    endfunction

    // Issues one request; returns edges from acceptance to the first cycle with
    // out_valid high (acceptance edge counts as 1), or -1 on timeout. Ends at a negedge.
    task automatic run_req(input logic [8*ML-1:0] pw, input int len, input int step, output int l);
        @(negedge clk);
        in_password = pw;
        in_length   = LW'(len);
        in_step     = 8'(step);
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        l = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid) return;
            @(posedge clk);
            l++;
        end
        l = -1;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_password !== '0) $display("FAIL reset_password got %h want 0", out_password); else n_pass++;
        n_total++; if (out_length !== 5'd0) $display("FAIL reset_length got %0d want 0", out_length); else n_pass++;
        n_total++; if (out_exhausted !== 1'b0) $display("FAIL reset_exhausted got %b want 0", out_exhausted); else n_pass++;
        n_total++; if (out_error !== 1'b0) $display("FAIL reset_error got %b want 0", out_error); else n_pass++;
    endtask

    task automatic test_single_digit();
        run_req(pw_of("a"), 1, 1, lat);
        n_total++; if (lat != 3) $display("FAIL single_latency got %0d want 3", lat); else n_pass++;
        n_total++; if (out_password !== pw_of("b")) $display("FAIL single_pw got %h want %h", out_password, pw_of("b")); else n_pass++;
        n_total++; if (out_length !== 5'd1) $display("FAIL single_len got %0d want 1", out_length); else n_pass++;
        n_total++; if (out_exhausted !== 1'b0 || out_error !== 1'b0) $display("FAIL single_flags got %b%b want 00", out_exhausted, out_error); else n_pass++;
        accept();
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL single_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_carry();
        run_req(pw_of("a~"), 2, 1, lat);
        n_total++; if (lat != 4) $display("FAIL carry_latency got %0d want 4", lat); else n_pass++;
        n_total++; if (out_password !== pw_of("b ") || out_length !== 5'd2) $display("FAIL carry_pw got %h/%0d want %h/2", out_password, out_length, pw_of("b ")); else n_pass++;
        accept();
        run_req(pw_of("A}"), 2, 5, lat);
        n_total++; if (out_password !== pw_of("B#") || out_length !== 5'd2) $display("FAIL carry_step5 got %h/%0d want %h/2", out_password, out_length, pw_of("B#")); else n_pass++;
        accept();
    endtask

    task automatic test_grow();
        run_req(pw_of("~~"), 2, 1, lat);
        n_total++; if (out_password !== pw_of("   ") || out_length !== 5'd3) $display("FAIL grow_pw got %h/%0d want %h/3", out_password, out_length, pw_of("   ")); else n_pass++;
        n_total++; if (out_exhausted !== 1'b0 || lat != 4) $display("FAIL grow_exh_lat got exh=%b lat=%0d want exh=0 lat=4", out_exhausted, lat); else n_pass++;
        accept();
        run_req(pw_of("}"), 1, 3, lat);
        n_total++; if (out_password !== pw_of(" !") || out_length !== 5'd2) $display("FAIL grow_step3 got %h/%0d want %h/2", out_password, out_length, pw_of(" !")); else n_pass++;
        accept();
    endtask

    task automatic test_len0_step0();
        run_req('0, 0, 1, lat);
        n_total++; if (lat != 2) $display("FAIL len0_latency got %0d want 2", lat); else n_pass++;
        n_total++; if (out_password !== pw_of(" ") || out_length !== 5'd1) $display("FAIL len0_step1 got %h/%0d want %h/1", out_password, out_length, pw_of(" ")); else n_pass++;
        accept();
        run_req('0, 0, 5, lat);
        n_total++; if (out_password !== pw_of("$") || out_length !== 5'd1) $display("FAIL len0_step5 got %h/%0d want %h/1", out_password, out_length, pw_of("$")); else n_pass++;
        accept();
        run_req(pw_of("Q"), 1, 0, lat);
        n_total++; if (lat != 2 || out_password !== pw_of("Q") || out_length !== 5'd1) $display("FAIL step0_pass got %h/%0d lat %0d want %h/1 lat 2", out_password, out_length, lat, pw_of("Q")); else n_pass++;
        accept();
    endtask

    task automatic test_exhaust();
        logic [8*ML-1:0] p = '0;
        for (int i = 0; i < ML; i++) p[8*ML-1-8*i -: 8] = 8'h7E;
        run_req(p, 20, 1, lat);
        n_total++; if (lat != 22) $display("FAIL exh_latency got %0d want 22", lat); else n_pass++;
        n_total++; if (out_exhausted !== 1'b1 || out_error !== 1'b0) $display("FAIL exh_flags got %b%b want 10", out_exhausted, out_error); else n_pass++;
        n_total++; if (out_password !== p || out_length !== 5'd20) $display("FAIL exh_pw got %h/%0d want %h/20", out_password, out_length, p); else n_pass++;
        accept();
    endtask

    task automatic test_error();
        logic [8*ML-1:0] p;
        run_req(pw_of("a"), 1, 95, lat);
        n_total++; if (out_error !== 1'b1 || lat != 2) $display("FAIL err_step95 got err=%b lat=%0d want err=1 lat=2", out_error, lat); else n_pass++;
        n_total++; if (out_password !== pw_of("a") || out_length !== 5'd1) $display("FAIL err_step95_pw got %h/%0d want %h/1", out_password, out_length, pw_of("a")); else n_pass++;
        accept();
        p = pw_of("xab");
        p[8*ML-1 -: 8] = 8'h19;
        run_req(p, 3, 1, lat);
        n_total++; if (out_error !== 1'b1 || out_password !== p) $display("FAIL err_badchar got err=%b pw=%h want err=1 pw=%h", out_error, out_password, p); else n_pass++;
        accept();
        run_req(pw_of("abc"), 21, 1, lat);
        n_total++; if (out_error !== 1'b1 || out_length !== 5'd21) $display("FAIL err_len21 got err=%b len=%0d want err=1 len=21", out_error, out_length); else n_pass++;
        accept();
        p = pw_of("ab");
        p[8*ML-1-16 -: 8] = 8'h19;
        run_req(p, 2, 1, lat);
        n_total++; if (out_error !== 1'b0 || out_password !== pw_of("ac")) $display("FAIL mask_tail got err=%b pw=%h want err=0 pw=%h", out_error, out_password, pw_of("ac")); else n_pass++;
        accept();
    endtask

    task automatic test_stall();
        int bad = 0;
        run_req(pw_of("a"), 1, 1, lat);
        in_password = pw_of("zz");
        in_length   = 5'd2;
        in_step     = 8'd3;
        in_valid    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_password !== pw_of("b") || out_length !== 5'd1) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL stall_hold got %0d bad cycles want 0", bad); else n_pass++;
        in_valid = 1'b0;
        accept();
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL stall_ignored got %0d valid cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_digit();
        int bad = 0;
        @(negedge clk);
        in_password = pw_of("~~~~~");
        in_length   = 5'd5;
        in_step     = 8'd1;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL abort_state got v=%b r=%b want v=0 r=1", out_valid, in_ready); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL abort_no_pulse got %0d valid cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_req(pw_of("zz"), 2, 2, lat);
        n_total++; if (out_password !== pw_of("z|")) $display("FAIL b2b_first got %h want %h", out_password, pw_of("z|")); else n_pass++;
        accept();
        run_req(pw_of("z|"), 2, 2, lat);
        n_total++; if (out_password !== pw_of("z~") || out_length !== 5'd2) $display("FAIL b2b_second got %h/%0d want %h/2", out_password, out_length, pw_of("z~")); else n_pass++;
        accept();
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_carry();
        test_grow();
        test_len0_step0();
        test_exhaust();
        test_error();
        test_stall();
        test_reset_digit();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
